// File: rtl/arb_21_ctrl_pkg.sv
// Shared definitions for the two-requester arbiter: FSM encoding and default sizing.
package arb_21_defs;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BEATS = 16;

  // Grant states; encodings are fixed so checkers can decode state_dbg directly.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

endpackage

// File: rtl/arb_21_ctrl_if.sv
// Bundle of requester-side and downstream-side beat signals for arb_21_ctrl.
//
// Handshake: a beat moves across a channel on a rising clk edge where that
// channel's valid and ready are both high. A source keeps valid/data/last
// stable until the beat is taken. Ready never depends on the source's own valid.
interface arb_21_ctrl_if #(parameter int WIDTH = 8);

  logic             in_valid_0;
  logic             in_valid_1;
  logic [WIDTH-1:0] in_data_0;
  logic [WIDTH-1:0] in_data_1;
  logic             in_last_0;
  logic             in_last_1;
  logic             in_ready_0;
  logic             in_ready_1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             sel;
  logic             busy;

  // Arbiter side.
  modport slave (
    input  in_valid_0, in_valid_1, in_data_0, in_data_1, in_last_0, in_last_1,
    input  out_ready,
    output in_ready_0, in_ready_1, out_valid, out_data, out_last, sel, busy
  );

  // Environment side (requesters plus downstream sink).
  modport master (
    output in_valid_0, in_valid_1, in_data_0, in_data_1, in_last_0, in_last_1,
    output out_ready,
    input  in_ready_0, in_ready_1, out_valid, out_data, out_last, sel, busy
  );

endinterface

// File: rtl/arb_21_ctrl_mux_21w.sv
// WIDTH-bit 2:1 multiplexer used for the data, last and valid output paths.
module mux_21w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             sel,
  output logic [WIDTH-1:0] mux_out
);

  // Pure combinational select.
  always_comb begin
    mux_out = sel ? in_1 : in_0;
  end

endmodule

// File: rtl/arb_21_ctrl.sv
// Two-requester burst arbiter: round-robin on ties, a grant is held for a whole
// burst (until last) or until MAX_BEATS beats, then handed over without a bubble.
module arb_21_ctrl
  import arb_21_defs::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic            clk,
  input  logic            rst_n,
  arb_21_ctrl_if.slave    bus,
  output state_e          state_dbg
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic            rr_last_q, rr_last_d;  // requester served most recently
  logic [CW-1:0]   cnt_q, cnt_d;          // beats moved in the current grant

  logic            busy_w;
  logic            mux_valid;
  logic            xfer;
  logic [CW-1:0]   cnt_inc;
  logic            limit_hit;
  logic            rel;

  // Output steering; sel already matches the granted requester in GNTx.
  mux_21w #(.WIDTH(WIDTH)) u_mux_data (
    .in_0(bus.in_data_0), .in_1(bus.in_data_1), .sel(sel_q), .mux_out(bus.out_data)
  );
  mux_21w #(.WIDTH(1)) u_mux_last (
    .in_0(bus.in_last_0), .in_1(bus.in_last_1), .sel(sel_q), .mux_out(bus.out_last)
  );
  mux_21w #(.WIDTH(1)) u_mux_valid (
    .in_0(bus.in_valid_0), .in_1(bus.in_valid_1), .sel(sel_q), .mux_out(mux_valid)
  );

  assign busy_w         = (state_q != IDLE);
  assign bus.busy       = busy_w;
  assign bus.sel        = sel_q;
  assign bus.out_valid  = busy_w & mux_valid;
  assign bus.in_ready_0 = bus.out_ready & (state_q == GNT0);
  assign bus.in_ready_1 = bus.out_ready & (state_q == GNT1);
  assign state_dbg      = state_q;

  assign xfer      = bus.out_valid & bus.out_ready;
  assign cnt_inc   = cnt_q + CW'(1);
  assign limit_hit = (cnt_inc == CW'(MAX_BEATS));
  assign rel       = xfer & (bus.out_last | limit_hit);

  // Next-state: grant selection in IDLE, release/hand-over in GNTx.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie requester 0 wins only if requester 1 was served last.
        if (bus.in_valid_0 && (!bus.in_valid_1 || rr_last_q)) begin
          state_d = GNT0;
          sel_d   = 1'b0;
          cnt_d   = '0;
        end else if (bus.in_valid_1) begin
          state_d = GNT1;
          sel_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GNT0: begin
        if (rel) begin
          rr_last_d = 1'b0;
          cnt_d     = '0;
          if (bus.in_valid_1) begin
            state_d = GNT1;
            sel_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
      GNT1: begin
        if (rel) begin
          rr_last_d = 1'b1;
          cnt_d     = '0;
          if (bus.in_valid_0) begin
            state_d = GNT0;
            sel_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_arb_21_ctrl.sv
// Directed bench for arb_21_ctrl (MAX_BEATS=4 so the forced release is reachable).
module tb_arb_21_ctrl;
  import arb_21_defs::*;

  logic   clk;
  logic   rst_n;
  state_e state_dbg;
  int     checks;
  int     errors;

  arb_21_ctrl_if #(.WIDTH(8)) bus ();

  arb_21_ctrl #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no summary expected one");
    $fatal(1, "watchdog");
  end

  // One cycle: land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.in_valid_0 = 1'b0; bus.in_valid_1 = 1'b0;
    bus.in_last_0  = 1'b0; bus.in_last_1  = 1'b0;
    bus.in_data_0  = 8'h00; bus.in_data_1 = 8'h00;
    bus.out_ready  = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid_0 = 1'b1; bus.in_valid_1 = 1'b0;
    bus.in_last_0  = 1'b0; bus.in_last_1  = 1'b0;
    bus.in_data_0  = 8'h5a; bus.in_data_1 = 8'h00;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if ({bus.in_ready_0, bus.out_valid, bus.sel, bus.busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got rdy0/ov/sel/busy=%b expected 0000", i,
                 {bus.in_ready_0, bus.out_valid, bus.sel, bus.busy});
      end
      checks++;
      if (state_dbg !== IDLE) begin
        errors++; $display("FAIL reset_state: got %b expected %b", state_dbg, IDLE);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
    tick();
    checks++;
    if ({bus.busy, bus.sel, bus.in_ready_0, bus.out_valid} !== 4'b1011) begin
      errors++;
      $display("FAIL reset_first_grant: got busy/sel/rdy0/ov=%b expected 1011",
               {bus.busy, bus.sel, bus.in_ready_0, bus.out_valid});
    end
  endtask

  task automatic test_single();
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    apply_reset();
    bus.in_valid_0 = 1'b1; bus.in_data_0 = beats[0]; bus.in_last_0 = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle_ov: got %b expected 0", bus.out_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.in_data_0 = beats[i];
      bus.in_last_0 = (i == 2);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready_0, bus.in_ready_1, bus.sel} !== 4'b1100 ||
          bus.out_data !== beats[i] || bus.out_last !== (i == 2)) begin
        errors++;
        $display("FAIL single_beat[%0d]: got ov/r0/r1/sel=%b data=%h last=%b expected 1100 data=%h last=%b",
                 i, {bus.out_valid, bus.in_ready_0, bus.in_ready_1, bus.sel},
                 bus.out_data, bus.out_last, beats[i], (i == 2));
      end
      tick();
    end
    bus.in_valid_0 = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      errors++; $display("FAIL single_end_idle: got busy/ov=%b expected 00", {bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_tie();
    apply_reset();
    bus.in_valid_0 = 1'b1; bus.in_data_0 = 8'ha0; bus.in_last_0 = 1'b0;
    bus.in_valid_1 = 1'b1; bus.in_data_1 = 8'hb0; bus.in_last_1 = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.sel !== 1'b0 || bus.out_data !== 8'ha0 || bus.in_ready_1 !== 1'b0) begin
      errors++; $display("FAIL tie_first: got sel=%b data=%h r1=%b expected 0 a0 0", bus.sel, bus.out_data, bus.in_ready_1);
    end
    tick();
    bus.in_data_0 = 8'ha1; bus.in_last_0 = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 8'ha1 || bus.out_last !== 1'b1) begin
      errors++; $display("FAIL tie_a1: got data=%h last=%b expected a1 1", bus.out_data, bus.out_last);
    end
    tick();
    #1;
    checks++;
    if ({bus.busy, bus.sel, bus.in_ready_1, bus.in_ready_0} !== 4'b1110 || bus.out_data !== 8'hb0) begin
      errors++;
      $display("FAIL tie_handover: got busy/sel/r1/r0=%b data=%h expected 1110 b0",
               {bus.busy, bus.sel, bus.in_ready_1, bus.in_ready_0}, bus.out_data);
    end
    bus.in_valid_0 = 1'b0; bus.in_last_0 = 1'b0;
    tick();
    bus.in_data_1 = 8'hb1; bus.in_last_1 = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 8'hb1 || bus.out_last !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL tie_b1: got data=%h last=%b ov=%b expected b1 1 1", bus.out_data, bus.out_last, bus.out_valid);
    end
    tick();
    bus.in_valid_1 = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.sel !== 1'b1) begin
      errors++; $display("FAIL tie_idle_sel_hold: got busy=%b sel=%b expected 0 1", bus.busy, bus.sel);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    bus.in_valid_0 = 1'b1; bus.in_data_0 = 8'hc0; bus.in_last_0 = 1'b1;
    bus.in_valid_1 = 1'b1; bus.in_data_1 = 8'hc1; bus.in_last_1 = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      logic       exp_sel;
      logic [7:0] exp_data;
      exp_sel  = i[0];
      exp_data = exp_sel ? 8'hc1 : 8'hc0;
      #1;
      checks++;
      if (bus.sel !== exp_sel || bus.out_data !== exp_data || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got sel=%b data=%h ov=%b expected %b %h 1",
                 i, bus.sel, bus.out_data, bus.out_valid, exp_sel, exp_data);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.in_valid_1 = 1'b1; bus.in_data_1 = 8'h40; bus.in_last_1 = 1'b0;
    tick();
    bus.in_valid_0 = 1'b1; bus.in_data_0 = 8'h55; bus.in_last_0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data_1 = 8'h40 + 8'(i);
      #1;
      checks++;
      if (bus.sel !== 1'b1 || bus.out_data !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL timeout_ch1a[%0d]: got sel=%b data=%h expected 1 %h", i, bus.sel, bus.out_data, 8'h40 + 8'(i));
      end
      tick();
    end
    #1;
    checks++;
    if ({bus.busy, bus.sel, bus.in_ready_1} !== 3'b100 || bus.out_data !== 8'h55) begin
      errors++;
      $display("FAIL timeout_to_ch0: got busy/sel/r1=%b data=%h expected 100 55",
               {bus.busy, bus.sel, bus.in_ready_1}, bus.out_data);
    end
    tick();
    bus.in_valid_0 = 1'b0;
    for (int i = 4; i < 8; i++) begin
      bus.in_data_1 = 8'h40 + 8'(i);
      #1;
      checks++;
      if (bus.sel !== 1'b1 || bus.in_ready_1 !== 1'b1 || bus.out_data !== 8'h40 + 8'(i)) begin
        errors++;
        $display("FAIL timeout_ch1b[%0d]: got sel=%b r1=%b data=%h expected 1 1 %h",
                 i, bus.sel, bus.in_ready_1, bus.out_data, 8'h40 + 8'(i));
      end
      tick();
    end
    #1;
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      errors++; $display("FAIL timeout_same_idle: got busy/ov=%b expected 00", {bus.busy, bus.out_valid});
    end
    tick();
    checks++;
    if ({bus.busy, bus.sel} !== 2'b11) begin
      errors++; $display("FAIL timeout_regrant: got busy/sel=%b expected 11", {bus.busy, bus.sel});
    end
  endtask

  task automatic test_backpressure_abort();
    apply_reset();
    bus.in_valid_0 = 1'b1; bus.in_data_0 = 8'h71; bus.in_last_0 = 1'b0;
    tick();
    tick();
    bus.in_data_0 = 8'h72;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready_0, bus.busy, bus.sel} !== 4'b1010 || bus.out_data !== 8'h72) begin
        errors++;
        $display("FAIL stall[%0d]: got ov/r0/busy/sel=%b data=%h expected 1010 72",
                 i, {bus.out_valid, bus.in_ready_0, bus.busy, bus.sel}, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    // One beat went before the stall, so three more reach the 4-beat limit.
    for (int i = 0; i < 3; i++) begin
      bus.in_data_0 = 8'h72 + 8'(i);
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready_0 !== 1'b1) begin
        errors++; $display("FAIL stall_count[%0d]: got busy=%b r0=%b expected 1 1", i, bus.busy, bus.in_ready_0);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL stall_limit_release: got busy=%b expected 0", bus.busy);
    end
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.in_ready_0, bus.in_ready_1, bus.out_valid, bus.sel} !== 5'b00000 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL abort_async: got busy/r0/r1/ov/sel=%b state=%b expected 00000 00",
               {bus.busy, bus.in_ready_0, bus.in_ready_1, bus.out_valid, bus.sel}, state_dbg);
    end
    tick();
    rst_n = 1'b1;
    bus.in_valid_0 = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_timeout();
    test_backpressure_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_21_ctrl.md
ARB_21_CTRL -- requirements
Module: arb_21_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester channel.
REQ-002 Parameter: MAX_BEATS, default 16, maximum beats per grant before forced release (range 1..255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid_0 / in_valid_1  input  1  requester 0/1 has a beat.
REQ-006 Port: in_data_0 / in_data_1  input  WIDTH  requester 0/1 beat data.
REQ-007 Port: in_last_0 / in_last_1  input  1  beat is last of requester's burst.
REQ-008 Port: in_ready_0 / in_ready_1  output  1  beat accepted from requester 0/1.
REQ-009 Port: out_valid  output  1  selected beat valid.
REQ-010 Port: out_data  output  WIDTH  selected beat data.
REQ-011 Port: out_last  output  1  selected beat is last.
REQ-012 Port: out_ready  input  1  downstream accepts beat.
REQ-013 Port: sel  output  1  current mux select: 0 = requester 0, 1 = requester 1.
REQ-014 Port: busy  output  1  a grant is held (state not IDLE).

Function
REQ-015 FSM states: IDLE, GNT0, GNT1; state and sel registered.
REQ-016 IDLE: in_valid_0 only -> GNT0; in_valid_1 only -> GNT1; both -> requester not last served (rr_last bit); neither -> stay IDLE.
REQ-017 Grant latency: exactly 1 cycle from in_valid assertion in IDLE to first possible transfer.
REQ-018 sel updated on entry to GNT0 (0) / GNT1 (1); sel holds its value in IDLE.
REQ-019 out_valid = in_valid of granted requester when in GNTx, else 0; out_data/out_last = granted requester's data/last via sel (combinational).
REQ-020 in_ready_x = out_ready AND state==GNTx; non-granted in_ready always 0.
REQ-021 Transfer = out_valid AND out_ready; beat counter increments per transfer, cleared on grant entry.
REQ-022 Release from GNTx on transfer with out_last=1, or on transfer making beat count == MAX_BEATS.
REQ-023 On release: rr_last <= x; if the other requester's in_valid is high that cycle -> go directly to its GNT state (no IDLE bubble), else -> IDLE.
REQ-024 On release, if only the same requester is still valid -> return to IDLE, re-grant next cycle per REQ-016.
REQ-025 Granted requester deasserting in_valid mid-burst: grant held, no transfer, no timeout.
REQ-026 out_ready low: no transfer, counter and state frozen.
REQ-027 MAX_BEATS=1: each transfer releases; counter width ceil(log2(MAX_BEATS+1)).

Reset
REQ-028 rst_n low: state=IDLE, sel=0, rr_last=1 (requester 0 wins first tie), counter=0, asynchronously.
REQ-029 During/after reset: out_valid=0, in_ready_0=0, in_ready_1=0, busy=0; first grant no earlier than first rising clk edge after rst_n release.
REQ-030 Reset mid-burst aborts burst; no partial-burst state retained.

Structure
REQ-031 Shared package/include arb_21_defs: state encodings (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10), default WIDTH and MAX_BEATS constants.
REQ-032 One sub-module: mux_21w, a WIDTH-bit 2:1 mux (in_0, in_1, sel, mux_out) for out_data; out_last/out_valid selected with same sel.

Verification
REQ-033 Reset: rst_n=0 with in_valid_0=1 -> in_ready_0=0, out_valid=0, sel=0, busy=0 throughout.
REQ-034 Single requester: 3-beat burst on ch0 (data 0x11,0x22,0x33, last on 3rd), out_ready=1 -> GNT0 next cycle, 3 transfers on consecutive cycles, then IDLE.
REQ-035 Tie: both valid from reset, 2-beat bursts each -> ch0 bursts first, ch1 granted immediately after ch0 last transfer with no idle cycle, sel 0->1.
REQ-036 Fairness: both continuously valid, 1-beat bursts -> grants alternate 0,1,0,1; no requester served twice in a row.
REQ-037 Timeout: MAX_BEATS=4, ch1 sends 10 beats without last, ch0 valid -> after 4th ch1 transfer grant moves to ch0.
REQ-038 Backpressure/abort: out_ready low 5 cycles mid-burst -> data stable, counter frozen; assert rst_n=0 mid-burst -> IDLE, all ready 0 asynchronously.
